// File: rtl/gray_code_counter_param_pkg.sv
// Shared types and Gray/binary conversion helpers for the Gray code counter.
// Helpers operate on the widest supported count; callers zero-extend and truncate.
package gray_code_counter_param_pkg;

    localparam int unsigned MaxWidth = 16;

    typedef logic [MaxWidth-1:0] word_t;

    typedef enum logic [1:0] {
        OpHold,
        OpLoad,
        OpStep
    } op_e;

    function automatic word_t bin2gray(input word_t bin);
        return bin ^ (bin >> 1);
    endfunction

    function automatic word_t gray2bin(input word_t gray);
        word_t bin;
        bin[MaxWidth-1] = gray[MaxWidth-1];
        for (int i = MaxWidth - 2; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

endpackage

// File: rtl/rise_edge_detect.sv
// Single-cycle pulse on each 0->1 transition of a level input.
module rise_edge_detect (
    input  logic clk,
    input  logic reset,
    input  logic level,
    output logic pulse
);

    logic level_q;

    // Tracks the input even in reset so a level held across reset never pulses on release.
    always_ff @(posedge clk) begin
        if (reset) begin
            level_q <= level;
        end else begin
            level_q <= level;
        end
    end

    assign pulse = level & ~level_q;

endmodule

// File: rtl/gray_code_counter_param.sv
// Up/down event counter with load and wrap-or-saturate limits; count shown as Gray and binary.
module gray_code_counter_param
    import gray_code_counter_param_pkg::*;
#(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned WRAP  = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             trigger,
    input  logic             up_down,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] dataout,
    output logic [WIDTH-1:0] binary_out,
    output logic             limit
);

    localparam logic [WIDTH-1:0] MaxVal = '1;

    logic             step;
    op_e              op;
    logic [WIDTH-1:0] bin_q, bin_d;
    logic             limit_q, limit_d;

    rise_edge_detect u_trig_edge (
        .clk   (clk),
        .reset (reset),
        .level (trigger),
        .pulse (step)
    );

    // Load outranks a coincident step; the step is dropped, not deferred.
    always_comb begin
        op = OpHold;
        if (load) begin
            op = OpLoad;
        end else if (step) begin
            op = OpStep;
        end
    end

    always_comb begin
        bin_d   = bin_q;
        limit_d = 1'b0;
        unique case (op)
            OpLoad: bin_d = load_value;
            OpStep: begin
                if (up_down) begin
                    if (bin_q == MaxVal) begin
                        limit_d = 1'b1;
                        bin_d   = (WRAP != 0) ? '0 : MaxVal;
                    end else begin
                        bin_d = bin_q + WIDTH'(1);
                    end
                end else begin
                    if (bin_q == '0) begin
                        limit_d = 1'b1;
                        bin_d   = (WRAP != 0) ? MaxVal : '0;
                    end else begin
                        bin_d = bin_q - WIDTH'(1);
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bin_q   <= '0;
            limit_q <= 1'b0;
        end else begin
            bin_q   <= bin_d;
            limit_q <= limit_d;
        end
    end

    assign dataout    = WIDTH'(bin2gray(word_t'(bin_q)));
    assign binary_out = bin_q;
    assign limit      = limit_q;

endmodule

// File: tb/tb_gray_code_counter_param.sv
// Self-checking bench: three counter instances (4-bit wrap, 4-bit saturate, 8-bit wrap)
// share stimulus; a reference model queues expected outputs per clock.
module tb_gray_code_counter_param;
    import gray_code_counter_param_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b0, trigger = 1'b0, up_down = 1'b1, load = 1'b0;
    logic [3:0] lv4 = '0;
    logic [7:0] lv8 = '0;

    logic [3:0] dataout_a, binary_out_a, dataout_s, binary_out_s;
    logic [7:0] dataout_8, binary_out_8;
    logic       limit_a, limit_s, limit_8;

    gray_code_counter_param #(.WIDTH(4), .WRAP(1)) dut_a (
        .clk(clk), .reset(reset), .trigger(trigger), .up_down(up_down), .load(load),
        .load_value(lv4), .dataout(dataout_a), .binary_out(binary_out_a), .limit(limit_a)
    );
    gray_code_counter_param #(.WIDTH(4), .WRAP(0)) dut_s (
        .clk(clk), .reset(reset), .trigger(trigger), .up_down(up_down), .load(load),
        .load_value(lv4), .dataout(dataout_s), .binary_out(binary_out_s), .limit(limit_s)
    );
    gray_code_counter_param #(.WIDTH(8), .WRAP(1)) dut_8 (
        .clk(clk), .reset(reset), .trigger(trigger), .up_down(up_down), .load(load),
        .load_value(lv8), .dataout(dataout_8), .binary_out(binary_out_8), .limit(limit_8)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] ga; logic [3:0] ba; logic la;
        logic [3:0] gb; logic [3:0] bb; logic lb;
        logic [7:0] gc; logic [7:0] bc; logic lc;
    } exp_t;

    exp_t        sb[$];
    exp_t        e;
    logic [34:0] act;
    assign act = {dataout_a, binary_out_a, limit_a, dataout_s, binary_out_s, limit_s,
                  dataout_8, binary_out_8, limit_8};

    int    total = 0, bad = 0;
    logic  m_trig = 1'b0;
    word_t m_a = '0, m_b = '0, m_c = '0;

    // Returns {limit, next count}.
    function automatic logic [16:0] nxt(input word_t b, input int unsigned w, input bit wrap,
                                        input logic st, input logic ud, input logic ld,
                                        input logic rst, input word_t lv);
        word_t mx;
        mx = word_t'((32'd1 << w) - 32'd1);
        if (rst) return 17'd0;
        if (ld) return {1'b0, lv};
        if (!st) return {1'b0, b};
        if (ud) begin
            if (b == mx) return {1'b1, wrap ? 16'd0 : mx};
            return {1'b0, b + 16'd1};
        end
        if (b == 16'd0) return {1'b1, wrap ? mx : 16'd0};
        return {1'b0, b - 16'd1};
    endfunction

    task automatic tick(input logic t, input logic ud, input logic ld, input logic rst,
                        input logic [7:0] lv);
        logic        st;
        logic [16:0] r;
        exp_t        x;
        trigger = t; up_down = ud; load = ld; reset = rst;
        lv4 = lv[3:0]; lv8 = lv;
        st = t & ~m_trig;
        r = nxt(m_a, 4, 1'b1, st, ud, ld, rst, word_t'(lv[3:0]));
        m_a = r[15:0]; x.la = r[16];
        r = nxt(m_b, 4, 1'b0, st, ud, ld, rst, word_t'(lv[3:0]));
        m_b = r[15:0]; x.lb = r[16];
        r = nxt(m_c, 8, 1'b1, st, ud, ld, rst, word_t'(lv));
        m_c = r[15:0]; x.lc = r[16];
        x.ba = 4'(m_a); x.ga = 4'(bin2gray(m_a));
        x.bb = 4'(m_b); x.gb = 4'(bin2gray(m_b));
        x.bc = 8'(m_c); x.gc = 8'(bin2gray(m_c));
        m_trig = t;
        sb.push_back(x);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        for (int i = 0; i < 2; i++) begin
            tick(1'b0, 1'b1, 1'b0, 1'b1, 8'd0);
            e = sb.pop_front();
            total++;
            if (act !== e) begin bad++; $display("FAIL reset_model: got %h want %h", act, e); end
        end
        total++;
        if (act !== '0) begin bad++; $display("FAIL reset_zero: got %h want 0", act); end
    endtask

    task automatic test_count_up_wrap;
        logic [3:0] prev;
        prev = dataout_a;
        for (int i = 0; i < 16; i++) begin
            tick(1'b1, 1'b1, 1'b0, 1'b0, 8'd0);
            e = sb.pop_front();
            total++;
            if (act !== e) begin bad++; $display("FAIL up_step%0d: got %h want %h", i, act, e); end
            total++;
            if ($countones(dataout_a ^ prev) != 1) begin
                bad++; $display("FAIL up_onebit%0d: got %b after %b", i, dataout_a, prev);
            end
            total++;
            if (limit_a !== (i == 15)) begin
                bad++; $display("FAIL up_limit%0d: got %b want %b", i, limit_a, (i == 15));
            end
            total++;
            if (4'(gray2bin(word_t'(dataout_a))) !== binary_out_a) begin
                bad++; $display("FAIL up_g2b%0d: got %h want %h", i, binary_out_a, dataout_a);
            end
            prev = dataout_a;
            tick(1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
            e = sb.pop_front();
            total++;
            if (act !== e) begin bad++; $display("FAIL up_idle%0d: got %h want %h", i, act, e); end
        end
        total++;
        if (dataout_a !== 4'd0) begin bad++; $display("FAIL up_wrap_zero: got %h want 0", dataout_a); end
    endtask

    task automatic test_down_wrap;
        tick(1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
        e = sb.pop_front();
        total++;
        if (act !== e) begin bad++; $display("FAIL down_model: got %h want %h", act, e); end
        total++;
        if ({binary_out_a, dataout_a, limit_a} !== {4'd15, 4'b1000, 1'b1}) begin
            bad++; $display("FAIL down_wrap: got %h/%b/%b want f/1000/1",
                            binary_out_a, dataout_a, limit_a);
        end
        tick(1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
        e = sb.pop_front();
        total++;
        if (act !== e || limit_a !== 1'b0) begin
            bad++; $display("FAIL down_limit_clear: got %h want %h", act, e);
        end
    endtask

    task automatic test_saturate;
        tick(1'b0, 1'b1, 1'b1, 1'b0, 8'd15);
        e = sb.pop_front();
        total++;
        if (act !== e) begin bad++; $display("FAIL sat_load: got %h want %h", act, e); end
        for (int i = 0; i < 2; i++) begin
            tick(1'b1, 1'b1, 1'b0, 1'b0, 8'd0);
            e = sb.pop_front();
            total++;
            if (act !== e) begin bad++; $display("FAIL sat_up%0d: got %h want %h", i, act, e); end
            total++;
            if ({binary_out_s, limit_s} !== {4'd15, 1'b1}) begin
                bad++; $display("FAIL sat_hold%0d: got %h/%b want f/1", i, binary_out_s, limit_s);
            end
            tick(1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
            e = sb.pop_front();
            total++;
            if (act !== e) begin bad++; $display("FAIL sat_idle%0d: got %h want %h", i, act, e); end
        end
        tick(1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
        e = sb.pop_front();
        total++;
        if ({binary_out_s, dataout_s, limit_s} !== {4'd14, 4'b1001, 1'b0}) begin
            bad++; $display("FAIL sat_down: got %h/%b/%b want e/1001/0",
                            binary_out_s, dataout_s, limit_s);
        end
        tick(1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
        e = sb.pop_front();
        total++;
        if (act !== e) begin bad++; $display("FAIL sat_after: got %h want %h", act, e); end
    endtask

    task automatic test_load_priority;
        tick(1'b1, 1'b1, 1'b1, 1'b0, 8'd10);
        e = sb.pop_front();
        total++;
        if ({binary_out_a, dataout_a, limit_a} !== {4'd10, 4'b1111, 1'b0}) begin
            bad++; $display("FAIL load_prio: got %h/%b/%b want a/1111/0",
                            binary_out_a, dataout_a, limit_a);
        end
        tick(1'b1, 1'b1, 1'b0, 1'b0, 8'd10);
        e = sb.pop_front();
        total++;
        if (act !== e || binary_out_a !== 4'd10) begin
            bad++; $display("FAIL load_no_step: got %h want %h", act, e);
        end
        tick(1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
        e = sb.pop_front();
        total++;
        if (act !== e) begin bad++; $display("FAIL load_after: got %h want %h", act, e); end
    endtask

    task automatic test_hold_high;
        for (int i = 0; i < 20; i++) begin
            tick(1'b1, 1'b1, 1'b0, 1'b0, 8'd0);
            e = sb.pop_front();
            total++;
            if (act !== e) begin bad++; $display("FAIL hold%0d: got %h want %h", i, act, e); end
        end
        total++;
        if (binary_out_a !== 4'd11) begin
            bad++; $display("FAIL hold_once: got %0d want 11", binary_out_a);
        end
        for (int i = 0; i < 6; i++) begin
            tick(1'b1, 1'b1, 1'b0, (i < 3), 8'd0);
            e = sb.pop_front();
            total++;
            if (act !== e) begin bad++; $display("FAIL hold_rst%0d: got %h want %h", i, act, e); end
        end
        total++;
        if ({binary_out_a, binary_out_s, binary_out_8} !== 16'd0) begin
            bad++; $display("FAIL hold_rst_zero: got %h/%h/%h want 0",
                            binary_out_a, binary_out_s, binary_out_8);
        end
        tick(1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
        e = sb.pop_front();
        total++;
        if (act !== e) begin bad++; $display("FAIL hold_release: got %h want %h", act, e); end
    endtask

    task automatic test_mid_reset;
        for (int i = 0; i < 7; i++) begin
            tick(1'b1, 1'b1, 1'b0, 1'b0, 8'd0);
            e = sb.pop_front();
            tick(1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
            e = sb.pop_front();
            total++;
            if (act !== e) begin bad++; $display("FAIL mid_count%0d: got %h want %h", i, act, e); end
        end
        total++;
        if (binary_out_a !== 4'd7) begin bad++; $display("FAIL mid_seven: got %0d want 7", binary_out_a); end
        tick(1'b1, 1'b1, 1'b0, 1'b1, 8'd0);
        e = sb.pop_front();
        total++;
        if (act !== '0) begin bad++; $display("FAIL mid_reset: got %h want 0", act); end
        tick(1'b0, 1'b1, 1'b1, 1'b1, 8'd5);
        e = sb.pop_front();
        total++;
        if (act !== '0) begin bad++; $display("FAIL mid_reset_load: got %h want 0", act); end
        tick(1'b1, 1'b1, 1'b0, 1'b0, 8'd0);
        e = sb.pop_front();
        total++;
        if (act !== e) begin bad++; $display("FAIL mid_resume: got %h want %h", act, e); end
        tick(1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
        e = sb.pop_front();
    endtask

    task automatic test_wide_wrap;
        logic [7:0] prev;
        int         nlim;
        nlim = 0;
        tick(1'b0, 1'b1, 1'b0, 1'b1, 8'd0);
        e = sb.pop_front();
        prev = dataout_8;
        for (int i = 0; i < 256; i++) begin
            tick(1'b1, 1'b1, 1'b0, 1'b0, 8'd0);
            e = sb.pop_front();
            total++;
            if (act !== e) begin bad++; $display("FAIL wide_step%0d: got %h want %h", i, act, e); end
            total++;
            if ($countones(dataout_8 ^ prev) != 1) begin
                bad++; $display("FAIL wide_onebit%0d: got %h after %h", i, dataout_8, prev);
            end
            if (limit_8) nlim++;
            prev = dataout_8;
            tick(1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
            e = sb.pop_front();
            if (limit_8) nlim++;
        end
        total++;
        if (nlim != 1 || binary_out_8 !== 8'd0) begin
            bad++; $display("FAIL wide_wrap: got limits=%0d count=%0d want 1/0", nlim, binary_out_8);
        end
    endtask

    initial begin
        test_reset();
        test_count_up_wrap();
        test_down_wrap();
        test_saturate();
        test_load_priority();
        test_hold_high();
        test_mid_reset();
        test_wide_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
